// File: rtl/novram_seq.sv
// novram_seq: strobe sequencer for the 2804 NOVRAM on the I/O board.
// Turns 68k read/write requests into timed CE/OE/WE strobes with
// unlock-before-write protection and internal write-time hold-off.
// Optional build macro: NOVRAM_VERIFY_EN adds a read-back verify
// after each write and drives the sticky mismatch flag.
// Ports:
//   SC_1H, SYSRES          clock, async active-high reset
//   unlock                 pulse, arms exactly one write
//   req_wr/req_rd          level requests, held until ack/rd_valid
//   req_addr, req_data     request address and write data
//   rd_data                EEPROM data bus (input side)
//   E2PROM_b, OE_b, WL_b   active-low EEPROM strobes
//   A_out, D_out           registered address / write data
//   rd_q, rd_valid         captured read data and its pulse
//   ack, err_locked        write done / rejected pulses
//   busy, mismatch         not-IDLE flag, sticky verify failure
module novram_seq #(
  parameter int WR_CYCLES     = 16,
  parameter int STROBE_CYCLES = 2
) (
  input  logic        SC_1H,
  input  logic        SYSRES,
  input  logic        unlock,
  input  logic        req_wr,
  input  logic        req_rd,
  input  logic [10:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic [7:0]  rd_data,
  output logic        E2PROM_b,
  output logic        OE_b,
  output logic        WL_b,
  output logic [10:0] A_out,
  output logic [7:0]  D_out,
  output logic [7:0]  rd_q,
  output logic        rd_valid,
  output logic        ack,
  output logic        err_locked,
  output logic        busy,
  output logic        mismatch
);

  localparam int CW =
    ($clog2(WR_CYCLES) > 5) ? $clog2(WR_CYCLES) : 5;

`ifdef NOVRAM_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RCAPT, WVERIFY
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RCAPT
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [10:0]   a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic [7:0]    rdq_q, rdq_d;
  logic          rdv_q, rdv_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          sample;
`ifdef NOVRAM_VERIFY_EN
  logic          mis_q, mis_d;
`endif

  // The requester only drops its level in the cycle after ack or
  // rd_valid, so IDLE ignores requests during that pulse cycle.
  assign sample = !ack_q && !rdv_q;

  always_ff @(posedge SC_1H or posedge SYSRES) begin
    if (SYSRES) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      rdq_q   <= '0;
      rdv_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef NOVRAM_VERIFY_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      a_q     <= a_d;
      d_q     <= d_d;
      rdq_q   <= rdq_d;
      rdv_q   <= rdv_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef NOVRAM_VERIFY_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | unlock;
    a_d     = a_q;
    d_d     = d_q;
    rdq_d   = rdq_q;
    rdv_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef NOVRAM_VERIFY_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sample) begin
          // an unlock in the sampling cycle still arms this write
          if (req_wr && (armed_q || unlock)) begin
            state_d = WSETUP;
            a_d     = req_addr;
            d_d     = req_data;
          end else if (req_wr) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (req_rd) begin
            state_d = RSETUP;
            a_d     = req_addr;
          end
        end
      end
      WSETUP: begin
        state_d = WSTROBE;
        cnt_d   = CW'(STROBE_CYCLES - 1);
        // arming is consumed here; a fresh unlock re-arms
        armed_d = unlock;
      end
      WSTROBE: begin
        if (cnt_q == '0) begin
          state_d = WHOLD;
          cnt_d   = CW'(WR_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WHOLD: begin
        if (cnt_q == '0) begin
`ifdef NOVRAM_VERIFY_EN
          state_d = WVERIFY;
          cnt_d   = CW'(1);
`else
          state_d = IDLE;
          ack_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RSETUP: state_d = RCAPT;
      RCAPT: begin
        state_d = IDLE;
        rdq_d   = rd_data;
        rdv_d   = 1'b1;
      end
`ifdef NOVRAM_VERIFY_EN
      WVERIFY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          if (rd_data != d_q) mis_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset releases them at once.
  always_comb begin
    E2PROM_b = 1'b1;
    OE_b     = 1'b1;
    WL_b     = 1'b1;
    busy     = (state_q != IDLE);
    unique case (state_q)
      WSETUP:  E2PROM_b = 1'b0;
      WSTROBE: begin
        E2PROM_b = 1'b0;
        WL_b     = 1'b0;
      end
      RSETUP, RCAPT: begin
        E2PROM_b = 1'b0;
        OE_b     = 1'b0;
      end
`ifdef NOVRAM_VERIFY_EN
      WVERIFY: begin
        E2PROM_b = 1'b0;
        OE_b     = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign A_out      = a_q;
  assign D_out      = d_q;
  assign rd_q       = rdq_q;
  assign rd_valid   = rdv_q;
  assign ack        = ack_q;
  assign err_locked = err_q;
`ifdef NOVRAM_VERIFY_EN
  assign mismatch   = mis_q;
`else
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_novram_seq.sv
// tb_novram_seq: directed bench for novram_seq with an EEPROM model
// and an event scoreboard for ack / rd_valid.
module tb_novram_seq;

`ifdef NOVRAM_VERIFY_EN
  localparam int VL = 2;
`else
  localparam int VL = 0;
`endif

  logic        clk = 1'b0;
  logic        SYSRES, unlock, req_wr, req_rd;
  logic [10:0] req_addr;
  logic [7:0]  req_data, rd_data;
  logic        E2PROM_b, OE_b, WL_b;
  logic [10:0] A_out;
  logic [7:0]  D_out, rd_q;
  logic        rd_valid, ack, err_locked, busy, mismatch;

  always #5 clk = ~clk;

  novram_seq dut (
    .SC_1H(clk), .SYSRES(SYSRES), .unlock(unlock),
    .req_wr(req_wr), .req_rd(req_rd),
    .req_addr(req_addr), .req_data(req_data),
    .rd_data(rd_data),
    .E2PROM_b(E2PROM_b), .OE_b(OE_b), .WL_b(WL_b),
    .A_out(A_out), .D_out(D_out), .rd_q(rd_q),
    .rd_valid(rd_valid), .ack(ack),
    .err_locked(err_locked), .busy(busy),
    .mismatch(mismatch)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM model: unwritten cells read addr[7:0]^A5
  logic [7:0] mem [0:2047];
  bit         wv  [0:2047];
  logic [7:0] cmask = 8'h00;
  always @(posedge clk)
    if (!WL_b && !E2PROM_b) begin
      mem[A_out] <= D_out;
      wv[A_out]  <= 1'b1;
    end
  assign rd_data =
    (wv[A_out] ? mem[A_out] : (A_out[7:0] ^ 8'hA5)) ^ cmask;

  typedef struct {
    bit         rd;
    bit         err;
    logic [7:0] data;
    int         c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   wl_c[$], oe_c[$], ce_c[$];
  int   tests = 0, fails = 0;
  int   t0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (WL_b === 1'b0)     wl_c.push_back(cyc);
    if (OE_b === 1'b0)     oe_c.push_back(cyc);
    if (E2PROM_b === 1'b0) ce_c.push_back(cyc);
    if (ack === 1'b1 || rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_event: ack=%0b rd_valid=%0b cyc=%0d, expected none",
               ack, rd_valid, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.c);
        chk("event_kind", {31'd0, rd_valid}, {31'd0, e.rd});
        if (e.rd)
          chk("rd_q", {24'd0, rd_q}, {24'd0, e.data});
        else
          chk("err_locked", {31'd0, err_locked},
              {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_unlock();
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
  endtask

  task automatic clrq();
    wl_c.delete();
    oe_c.delete();
    ce_c.delete();
  endtask

  // requester model: drop each level the cycle after its response
  task automatic run(int maxc);
    bit a, r, done;
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      a = ack;
      r = rd_valid;
      tick();
      if (a) req_wr = 1'b0;
      if (r) req_rd = 1'b0;
      if (sb.size() == 0 && !req_wr && !req_rd) begin
        done = 1'b1;
        break;
      end
    end
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL timeout: observed %0d pending expected 0",
             sb.size());
      sb.delete();
      req_wr = 1'b0;
      req_rd = 1'b0;
    end
  endtask

  initial begin
    SYSRES   = 1'b1;
    unlock   = 1'b0;
    req_wr   = 1'b0;
    req_rd   = 1'b0;
    req_addr = '0;
    req_data = '0;
    tick();
    tick();
    SYSRES = 1'b0;
    tick();

    // reset state
    chk("rst_strobes", {29'd0, E2PROM_b, OE_b, WL_b}, 32'd7);
    chk("rst_A_out", {21'd0, A_out}, 32'd0);
    chk("rst_D_rdq", {16'd0, D_out, rd_q}, 32'd0);
    chk("rst_flags",
        {27'd0, rd_valid, ack, err_locked, busy, mismatch},
        32'd0);

    // write with no unlock since reset is rejected
    clrq();
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h044;
    req_data = 8'h3C;
    sb.push_back(exp_t'{rd:1'b0, err:1'b1, data:8'h00, c:t0 + 1});
    run(10);
    chk("rej_wl_count", wl_c.size(), 0);
    chk("rej_ce_count", ce_c.size(), 0);

    // armed write 0x155 <= 0xA5
    pulse_unlock();
    clrq();
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h155;
    req_data = 8'hA5;
    sb.push_back(exp_t'{rd:1'b0, err:1'b0, data:8'h00,
                        c:t0 + 20 + VL});
    tick();
    chk("wsetup_busy", {31'd0, busy}, 32'd1);
    run(40);
    chk("wl_count", wl_c.size(), 2);
    chk("wl_first", wl_c[0], t0 + 2);
    chk("wl_last", wl_c[wl_c.size() - 1], t0 + 3);
    chk("ce_first", ce_c[0], t0 + 1);
    chk("A_out", {21'd0, A_out}, 32'h155);
    chk("D_out", {24'd0, D_out}, 32'hA5);

    // arming is single-use
    clrq();
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h156;
    req_data = 8'h01;
    sb.push_back(exp_t'{rd:1'b0, err:1'b1, data:8'h00, c:t0 + 1});
    run(10);
    chk("rej2_wl_count", wl_c.size(), 0);

    // read 0x7FF (model returns 0x5A)
    clrq();
    t0 = cyc;
    req_rd   = 1'b1;
    req_addr = 11'h7FF;
    sb.push_back(exp_t'{rd:1'b1, err:1'b0, data:8'h5A, c:t0 + 3});
    run(10);
    chk("oe_count", oe_c.size(), 2);
    chk("oe_first", oe_c[0], t0 + 1);
    chk("oe_last", oe_c[oe_c.size() - 1], t0 + 2);
    chk("rd_A_out", {21'd0, A_out}, 32'h7FF);

    // read raised during WHOLD waits for ack; reads back 0x155
    pulse_unlock();
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h0AA;
    req_data = 8'h11;
    sb.push_back(exp_t'{rd:1'b0, err:1'b0, data:8'h00,
                        c:t0 + 20 + VL});
    repeat (6) tick();
    chk("whold_busy", {31'd0, busy}, 32'd1);
    req_rd   = 1'b1;
    req_addr = 11'h155;
    sb.push_back(exp_t'{rd:1'b1, err:1'b0, data:8'hA5,
                        c:t0 + 24 + VL});
    run(60);

    // simultaneous armed write and read: write first
    pulse_unlock();
    t0 = cyc;
    req_wr   = 1'b1;
    req_rd   = 1'b1;
    req_addr = 11'h200;
    req_data = 8'h77;
    sb.push_back(exp_t'{rd:1'b0, err:1'b0, data:8'h00,
                        c:t0 + 20 + VL});
    sb.push_back(exp_t'{rd:1'b1, err:1'b0, data:8'h77,
                        c:t0 + 24 + VL});
    run(60);

    // unlock in the sampling cycle arms the write
    t0 = cyc;
    unlock   = 1'b1;
    req_wr   = 1'b1;
    req_addr = 11'h301;
    req_data = 8'hC3;
    sb.push_back(exp_t'{rd:1'b0, err:1'b0, data:8'h00,
                        c:t0 + 20 + VL});
    tick();
    unlock = 1'b0;
    run(40);

    // reset during WSTROBE aborts the write
    pulse_unlock();
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h123;
    req_data = 8'h42;
    tick();
    tick();
    chk("wstrobe_wl", {31'd0, WL_b}, 32'd0);
    #2 SYSRES = 1'b1;
    #1;
    chk("async_wl", {31'd0, WL_b}, 32'd1);
    chk("async_ce", {31'd0, E2PROM_b}, 32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    req_wr = 1'b0;
    #1 SYSRES = 1'b0;
    repeat (25) tick();
    // armed was cleared by the reset
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h124;
    req_data = 8'h43;
    sb.push_back(exp_t'{rd:1'b0, err:1'b1, data:8'h00, c:t0 + 1});
    run(10);

`ifdef NOVRAM_VERIFY_EN
    chk("mis_clean", {31'd0, mismatch}, 32'd0);
    cmask = 8'h01;
    pulse_unlock();
    t0 = cyc;
    req_wr   = 1'b1;
    req_addr = 11'h300;
    req_data = 8'h99;
    sb.push_back(exp_t'{rd:1'b0, err:1'b0, data:8'h00,
                        c:t0 + 22});
    run(40);
    cmask = 8'h00;
    chk("mis_set", {31'd0, mismatch}, 32'd1);
`else
    chk("mis_tied", {31'd0, mismatch}, 32'd0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
